// File: rtl/move_cmd_queue.sv
// move_cmd_queue: collects single-cycle move requests from the button
// controllers into per-source pending flags, arbitrates them in fixed
// priority (drop > rotate > left > right) into a small command FIFO and
// presents the head command to the game engine with a valid/ready handshake.
module move_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          left_pulse,
  input  logic          right_pulse,
  input  logic          rotate_pulse,
  input  logic          drop_pulse,
  input  logic          flush,
  input  logic          cmd_ready,
  output logic          cmd_valid,
  output logic [CW-1:0] cmd_code,
  output logic [3:0]    fifo_count,
  output logic          coalesce_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0]    DEPTH_CNT = 4'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  localparam logic [CW-1:0] CODE_NONE   = CW'(0);
  localparam logic [CW-1:0] CODE_LEFT   = CW'(1);
  localparam logic [CW-1:0] CODE_RIGHT  = CW'(2);
  localparam logic [CW-1:0] CODE_ROTATE = CW'(3);
  localparam logic [CW-1:0] CODE_DROP   = CW'(4);

  // Pending request flags, one per source
  logic pend_left;
  logic pend_right;
  logic pend_rotate;
  logic pend_drop;

  logic pend_left_next;
  logic pend_right_next;
  logic pend_rotate_next;
  logic pend_drop_next;

  // Command storage and pointers
  logic [CW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_next;
  logic [PW-1:0] wr_ptr_next;

  // Request qualification and arbitration results
  logic          left_req;
  logic          right_req;
  logic          pop;
  logic          can_accept;
  logic          any_pend;
  logic          push;
  logic          sel_left;
  logic          sel_right;
  logic          sel_rotate;
  logic          sel_drop;
  logic [CW-1:0] push_code;
  logic          merge;

  // Next-state values for the registered outputs
  logic [3:0]    count_next;
  logic [3:0]    remain;
  logic [CW-1:0] head_next;
  logic          valid_next;
  logic          err_next;

  // Pointer advance with wrap at DEPTH so non-power-of-two depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Qualify incoming pulses and pick the single command pushed this cycle
  always_comb begin
    // Opposing horizontal requests cancel each other out entirely
    left_req  = left_pulse & ~right_pulse;
    right_req = right_pulse & ~left_pulse;

    pop        = cmd_valid & cmd_ready;
    can_accept = (fifo_count < DEPTH_CNT) | pop;
    any_pend   = pend_left | pend_right | pend_rotate | pend_drop;
    push       = any_pend & can_accept;

    sel_drop   = push & pend_drop;
    sel_rotate = push & ~pend_drop & pend_rotate;
    sel_left   = push & ~pend_drop & ~pend_rotate & pend_left;
    sel_right  = push & ~pend_drop & ~pend_rotate & ~pend_left & pend_right;

    push_code = CODE_NONE;
    if (sel_drop) begin
      push_code = CODE_DROP;
    end else if (sel_rotate) begin
      push_code = CODE_ROTATE;
    end else if (sel_left) begin
      push_code = CODE_LEFT;
    end else if (sel_right) begin
      push_code = CODE_RIGHT;
    end

    // A pulse landing on a flag that is not leaving this cycle is lost
    // into the existing request; one leaving this cycle re-arms instead
    merge = (pend_left   & ~sel_left   & left_req)    |
            (pend_right  & ~sel_right  & right_req)   |
            (pend_rotate & ~sel_rotate & rotate_pulse) |
            (pend_drop   & ~sel_drop   & drop_pulse);
  end

  // Work out the next pending flags, pointers, count and head entry
  always_comb begin
    pend_left_next   = (pend_left   & ~sel_left)   | left_req;
    pend_right_next  = (pend_right  & ~sel_right)  | right_req;
    pend_rotate_next = (pend_rotate & ~sel_rotate) | rotate_pulse;
    pend_drop_next   = (pend_drop   & ~sel_drop)   | drop_pulse;

    rd_ptr_next = pop  ? ptr_inc(rd_ptr) : rd_ptr;
    wr_ptr_next = push ? ptr_inc(wr_ptr) : wr_ptr;

    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + 4'd1;
    end else if (pop && !push) begin
      count_next = fifo_count - 4'd1;
    end

    // When the surviving entries run out the new head is the word being
    // written this cycle, which is not yet visible in the storage array
    remain = fifo_count - {3'b000, pop};
    if (remain == 4'd0) begin
      head_next = push ? push_code : CODE_NONE;
    end else begin
      head_next = mem[rd_ptr_next];
    end

    err_next = coalesce_err | merge;

    // Flush wipes every queued and pending command but keeps the error flag
    if (flush) begin
      pend_left_next   = 1'b0;
      pend_right_next  = 1'b0;
      pend_rotate_next = 1'b0;
      pend_drop_next   = 1'b0;
      rd_ptr_next      = '0;
      wr_ptr_next      = '0;
      count_next       = 4'd0;
      head_next        = CODE_NONE;
      err_next         = coalesce_err;
    end

    valid_next = (count_next != 4'd0);
  end

  // Write the arbitrated command into the FIFO storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= push_code;
    end
  end

  // Register the pending flags, pointers and all outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_left    <= 1'b0;
      pend_right   <= 1'b0;
      pend_rotate  <= 1'b0;
      pend_drop    <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fifo_count   <= 4'd0;
      cmd_valid    <= 1'b0;
      cmd_code     <= CODE_NONE;
      coalesce_err <= 1'b0;
    end else begin
      pend_left    <= pend_left_next;
      pend_right   <= pend_right_next;
      pend_rotate  <= pend_rotate_next;
      pend_drop    <= pend_drop_next;
      rd_ptr       <= rd_ptr_next;
      wr_ptr       <= wr_ptr_next;
      fifo_count   <= count_next;
      cmd_valid    <= valid_next;
      cmd_code     <= head_next;
      coalesce_err <= err_next;
    end
  end

endmodule
